// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divide controller.
// Contents:
//   div_state_e  - controller FSM state encoding
//   OP_*         - bit positions inside the one-hot divide opcode {modu, mod, divu, div}
//   DIVZ_QUOT    - quotient returned for a zero divisor when the bypass is built in
//   op_is_quot   - true when the opcode selects the quotient rather than the remainder
package div_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } div_state_e;

  localparam int unsigned OP_DIV  = 0;
  localparam int unsigned OP_DIVU = 1;
  localparam int unsigned OP_MOD  = 2;
  localparam int unsigned OP_MODU = 3;

  localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;

  function automatic logic op_is_quot(input logic [3:0] op);
    return op[OP_DIV] | op[OP_DIVU];
  endfunction

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage divide controller. Accepts one divide/modulo instruction at a time, latches its
// operands and destination tag, drives the shared multi-cycle divider, and holds the selected
// result for the MEM stage until it is taken. A pipeline flush while the divider is running
// parks the controller in DRAIN so the divider can finish the cancelled operation silently.
//
// Build option: DIV_ZERO_BYPASS_EN - when defined, a nonzero op with a zero divisor skips the
// divider and completes immediately with the architectural divide-by-zero result and
// out_divz set. When undefined, zero divisors go to the divider and out_divz is tied low.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   in_valid/in_ready          instruction handshake (ready only while idle)
//   in_op, in_src1, in_src2    one-hot op {modu, mod, divu, div}, dividend, divisor
//   in_rd                      destination register tag
//   flush                      pipeline cancel
//   div_op, div_src1, div_src2 request to the divider (op held until div_complete)
//   div_complete, div_quot/rem divider result
//   out_valid/out_ready        result handshake toward MEM
//   out_result, out_rd, out_divz  result, tag, divide-by-zero flag
//   busy                       controller not idle (hazard logic)
module ex_div_ctrl
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [3:0]  div_op,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  input  logic        div_complete,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_divz,
  output logic        busy
);

  div_state_e  r_state;
  logic [3:0]  r_op;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
`ifdef DIV_ZERO_BYPASS_EN
  logic        r_divz;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_op     <= 4'b0000;
      r_src1   <= 32'd0;
      r_src2   <= 32'd0;
      r_result <= 32'd0;
      r_rd     <= 5'd0;
`ifdef DIV_ZERO_BYPASS_EN
      r_divz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && !flush) begin
            r_op   <= in_op;
            r_src1 <= in_src1;
            r_src2 <= in_src2;
            r_rd   <= in_rd;
`ifdef DIV_ZERO_BYPASS_EN
            r_divz <= 1'b0;
`endif
            if (in_op == 4'b0000) begin
              // No operation selected: complete immediately with a zero result.
              r_result <= 32'd0;
              r_state  <= StDone;
`ifdef DIV_ZERO_BYPASS_EN
            end else if (in_src2 == 32'd0) begin
              r_result <= op_is_quot(in_op) ? DIVZ_QUOT : in_src1;
              r_divz   <= 1'b1;
              r_state  <= StDone;
`endif
            end else begin
              r_state <= StBusy;
            end
          end
        end
        StBusy: begin
          if (flush) begin
            // A result arriving with the flush is simply dropped; otherwise wait it out.
            r_state <= div_complete ? StIdle : StDrain;
          end else if (div_complete) begin
            r_result <= op_is_quot(r_op) ? div_quot : div_rem;
            r_state  <= StDone;
          end
        end
        StDone: begin
          if (out_ready || flush) begin
            r_state <= StIdle;
          end
        end
        StDrain: begin
          if (div_complete) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign in_ready   = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign out_valid  = (r_state == StDone);
  assign div_op     = ((r_state == StBusy) || (r_state == StDrain)) ? r_op : 4'b0000;
  assign div_src1   = r_src1;
  assign div_src2   = r_src2;
  assign out_result = r_result;
  assign out_rd     = r_rd;
`ifdef DIV_ZERO_BYPASS_EN
  assign out_divz   = r_divz;
`else
  assign out_divz   = 1'b0;
`endif

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Bench for ex_div_ctrl: a behavioural divider answers div_op after a programmable delay,
// directed instructions push hand-computed results into a scoreboard, and a monitor pops
// and compares on every out_valid/out_ready handshake.
module tb_ex_div_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rd;
  logic        flush;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_complete;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_divz;
  logic        busy;

  ex_div_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .in_rd        (in_rd),
    .flush        (flush),
    .div_op       (div_op),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_complete (div_complete),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_divz     (out_divz),
    .busy         (busy)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        divz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   div_lat = 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event within budget (t=%0t)", name, $time);
  endtask

  // Behavioural divider: starts when it sees a nonzero div_op, answers div_lat+1 cycles later.
  logic [3:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_run;
  int          m_cnt;
  logic        m_rst;

  initial begin
    div_complete = 1'b0;
    div_quot     = 32'd0;
    div_rem      = 32'd0;
    m_run        = 1'b0;
    m_cnt        = 0;
    forever begin
      @(posedge clk);
      m_rst = reset;
      #1;
      div_complete = 1'b0;
      if (m_rst) begin
        m_run = 1'b0;
      end else if (m_run) begin
        if (m_cnt == 0) begin
          div_complete = 1'b1;
          m_run        = 1'b0;
          if (m_b == 32'd0) begin
            div_quot = 32'hFFFF_FFFF;
            div_rem  = m_a;
          end else if (m_op[0] || m_op[2]) begin
            div_quot = $signed(m_a) / $signed(m_b);
            div_rem  = $signed(m_a) % $signed(m_b);
          end else begin
            div_quot = m_a / m_b;
            div_rem  = m_a % m_b;
          end
        end else begin
          m_cnt--;
        end
      end else if (div_op != 4'b0000) begin
        m_run = 1'b1;
        m_cnt = div_lat;
        m_op  = div_op;
        m_a   = div_src1;
        m_b   = div_src2;
      end
    end
  end

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_result", out_result, e.res);
        check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        check("out_divz", {31'd0, out_divz}, {31'd0, e.divz});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_rd    = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic divz);
    exp_t e;
    e.res  = res;
    e.rd   = rd;
    e.divz = divz;
    sb.push_back(e);
  endtask

  // Returns at the negedge of the cycle in which div_complete is high.
  task automatic wait_complete(input string name);
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (div_complete) break;
      n++;
    end
    if (n >= 50) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 50) timeout_fail(name);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 4'b0000;
    in_src1   = 32'd0;
    in_src2   = 32'd0;
    in_rd     = 5'd0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_div_op", {28'd0, div_op}, 32'd0);
    check("rst_out_divz", {31'd0, out_divz}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_div_src1", div_src1, 32'd0);
    check("rst_div_src2", div_src2, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // div 100/7 -> 14, op held until complete, result one cycle later
    div_lat = 2;
    push(32'd14, 5'd5, 1'b0);
    issue(4'b0001, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    check("div_op_div", {28'd0, div_op}, 32'h1);
    check("busy_in_busy", {31'd0, busy}, 32'd1);
    check("in_ready_in_busy", {31'd0, in_ready}, 32'd0);
    wait_complete("div_complete_1");
    check("div_op_held", {28'd0, div_op}, 32'h1);
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("idle_after_take", {31'd0, in_ready}, 32'd1);

    // modu 0xFFFFFFFF % 10 -> 5
    push(32'd5, 5'd7, 1'b0);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd10, 5'd7);
    @(negedge clk);
    check("div_op_modu", {28'd0, div_op}, 32'h8);
    wait_idle("idle_modu");

    // mod -7 % 2 (signed) -> -1
    push(32'hFFFF_FFFF, 5'd3, 1'b0);
    issue(4'b0100, 32'hFFFF_FFF9, 32'd2, 5'd3);
    wait_idle("idle_mod");

    // Flush two cycles after accept: drain silently
    div_lat = 4;
    issue(4'b0001, 32'd50, 32'd5, 5'd9);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_div_op", {28'd0, div_op}, 32'h1);
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    wait_complete("drain_complete");
    check("drain_in_ready_at_complete", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("drain_exit_in_ready", {31'd0, in_ready}, 32'd1);
    check("drain_exit_out_valid", {31'd0, out_valid}, 32'd0);

    // divu 9/3 after a drain -> 3
    div_lat = 2;
    push(32'd3, 5'd4, 1'b0);
    issue(4'b0010, 32'd9, 32'd3, 5'd4);
    wait_idle("idle_divu");

    // Flush in the same cycle as div_complete: result discarded
    issue(4'b0001, 32'd30, 32'd7, 5'd12);
    wait_complete("flush_complete");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_cpl_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_cpl_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    push(32'd3, 5'd11, 1'b0);
    issue(4'b0010, 32'd20, 32'd6, 5'd11);
    begin
      int n;
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        if (out_valid) break;
        n++;
      end
      if (n >= 50) timeout_fail("bp_out_valid");
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_result", out_result, 32'd3);
      check("bp_rd", {27'd0, out_rd}, 32'd11);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_idle", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in IDLE with in_valid: nothing accepted
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = 4'b0001;
    in_src1  = 32'd8;
    in_src2  = 32'd2;
    in_rd    = 5'd1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", {31'd0, busy}, 32'd0);
    check("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Zero opcode completes immediately with a zero result
    push(32'd0, 5'd2, 1'b0);
    issue(4'b0000, 32'd123, 32'd4, 5'd2);
    @(negedge clk);
    check("zero_op_out_valid", {31'd0, out_valid}, 32'd1);
    check("zero_op_div_op", {28'd0, div_op}, 32'd0);
    wait_idle("idle_zero_op");

    // div 5/0
`ifdef DIV_ZERO_BYPASS_EN
    push(32'hFFFF_FFFF, 5'd6, 1'b1);
    issue(4'b0001, 32'd5, 32'd0, 5'd6);
    @(negedge clk);
    check("divz_out_valid", {31'd0, out_valid}, 32'd1);
    check("divz_div_op", {28'd0, div_op}, 32'd0);
`else
    push(32'hFFFF_FFFF, 5'd6, 1'b0);
    issue(4'b0001, 32'd5, 32'd0, 5'd6);
    @(negedge clk);
    check("divz_div_op", {28'd0, div_op}, 32'h1);
`endif
    wait_idle("idle_divz");

    // Reset while BUSY
    div_lat = 4;
    issue(4'b0001, 32'd100, 32'd7, 5'd8);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy_div_op", {28'd0, div_op}, 32'd0);
    check("rst_busy_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy_src1", div_src1, 32'd0);

    repeat (8) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
